cacc_dual_reg_prog: RTL and testbench
=====================================

Name: cacc_dual_reg_prog

Overview:
Register-programming initiator for the CACC dual (D_*) register group. It is the master side of the reg_offset / reg_wr_en / reg_wr_data / reg_rd_data interface that the CACC dual register responder implements. It accepts one layer descriptor, writes all writable D_* registers, fires OP_ENABLE, polls op_en until the layer completes or a timeout occurs, then reads OUT_SATURATION and returns a completion record. It sits between the layer-descriptor queue and the CACC register slice.

Parameters:
POLL_GAP, 4, idle cycles between successive op_en polls; must be >= 1.
MAX_POLLS, 1024, number of polls that return op_en=1 before the timeout is declared; must be >= 1.
PCNT_W, 11, poll counter width; must satisfy 2^PCNT_W > MAX_POLLS.

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rst  in  1  synchronous reset, active-high
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor ready
desc_batches  in  5  batch count
desc_clip_truncate  in  5  clip truncate
desc_cya  in  32  CYA value
desc_dataout_addr  in  32  output address
desc_line_packed  in  1  line packed
desc_surf_packed  in  1  surface packed
desc_dataout_height  in  13  output height
desc_dataout_width  in  13  output width
desc_dataout_channel  in  13  output channel
desc_line_stride  in  24  line stride
desc_surf_stride  in  24  surface stride
desc_conv_mode  in  1  conv mode
desc_proc_precision  in  2  precision
reg_offset  out  12  register offset, registered
reg_wr_en  out  1  write strobe, registered
reg_wr_data  out  32  write data, registered
reg_rd_data  in  32  combinational read data for the current reg_offset
done_valid  out  1  completion valid
done_ready  in  1  completion accepted
done_sat_count  out  32  OUT_SATURATION value read back
done_timeout  out  1  1 = poll limit hit
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (nvdla_core_clk). Reset nvdla_core_rst is synchronous and active-high.
- Reset values: state IDLE; reg_offset=0, reg_wr_en=0, reg_wr_data=0; done_valid=0, done_sat_count=0, done_timeout=0; busy=0; desc_ready=1.
- Reset mid-operation aborts immediately. No further writes or reads are issued, and any pending completion is discarded.
- States: IDLE, WRITE, WAIT, POLL, SAT, DONE.
- IDLE:
  - desc_ready=1.
  - On desc_valid&desc_ready, capture all desc_* fields into internal registers, clear the poll counter, go to WRITE with index 0.
- WRITE: one write per cycle, reg_wr_en=1, 11 cycles in this fixed order (offset: data):
  1. 0x00c: {18'b0, proc_precision, 11'b0, conv_mode}
  2. 0x010: {3'b0, height, 3'b0, width}
  3. 0x014: {19'b0, channel}
  4. 0x018: dataout_addr
  5. 0x01c: {27'b0, batches}
  6. 0x020: {8'b0, line_stride}
  7. 0x024: {8'b0, surf_stride}
  8. 0x028: {15'b0, surf_packed, 15'b0, line_packed}
  9. 0x02c: {27'b0, clip_truncate}
  10. 0x034: cya
  11. 0x008: 32'h1 (OP_ENABLE trigger, always last)
  - After index 10, go to WAIT. 0x030 (read-only) is never written.
- WAIT:
  - reg_wr_en=0 for exactly POLL_GAP cycles, then go to POLL.
- POLL: single cycle, reg_wr_en=0, reg_offset=0x008; sample reg_rd_data[0] in that same cycle.
  - If the bit is 0, go to SAT.
  - Otherwise increment the poll counter. If the counter reaches MAX_POLLS, set timeout and go to SAT; else go back to WAIT.
- SAT: single cycle, reg_offset=0x030, reg_wr_en=0; capture reg_rd_data into done_sat_count. Go to DONE.
- DONE:
  - done_valid=1, with done_sat_count and done_timeout held stable.
  - On done_ready, go to IDLE and clear done_valid the next cycle. done_sat_count and done_timeout hold their values until the next SAT.
- reg_wr_en is asserted only in WRITE. reg_wr_data is 0 in every non-WRITE state. reg_offset returns to 0 in IDLE and DONE.
- Timing, with the accept in cycle T:
  - Writes occur in T+1..T+11.
  - First POLL at T+12+POLL_GAP.
  - If op_en is 0 on the first poll: SAT at T+13+POLL_GAP, done_valid from T+14+POLL_GAP.
- desc_valid while busy is ignored (desc_ready=0). No descriptor is accepted in the cycle DONE exits.
- Captured fields are immune to desc_* changes after the accept.

Test Plan:
- Reset, then descriptor {height=7, width=15, channel=63, precision=2, conv_mode=1, addr=0x8000_0000} -> 11 writes in T+1..T+11, in order. 0x00c carries 0x0000_2001, 0x010 carries 0x0007_000F, 0x014 carries 0x3F, last write is 0x008 with data 1.
- Responder model: op_en=1 for 3 polls then 0, sat_count=0x1234, POLL_GAP=4 -> exactly 4 POLL cycles 5 cycles apart. Then one read of 0x030 and done_valid with sat_count=0x1234, timeout=0.
- op_en stuck at 1, MAX_POLLS=8 -> exactly 8 polls, then the SAT read, then done_timeout=1.
- Hold done_ready=0 for 10 cycles while toggling desc_valid -> done_valid and its outputs stay stable, desc_ready=0, no register activity.
- Assert reset at write index 5 -> next cycle reg_wr_en=0, state IDLE. A new descriptor restarts from offset 0x00c.
- Two back-to-back descriptors with done_ready tied to 1 -> the second is accepted one cycle after DONE exits. Its writes use the second descriptor's values with no carry-over.

Source files
------------

// File: rtl/cacc_dual_reg_prog.sv
// Register-programming initiator for the CACC dual register group: writes one layer
// descriptor, fires OP_ENABLE, polls op_en, then reads OUT_SATURATION.
module cacc_dual_reg_prog #(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1024,
    parameter int unsigned PCNT_W    = 11
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [4:0]  desc_batches,
    input  logic [4:0]  desc_clip_truncate,
    input  logic [31:0] desc_cya,
    input  logic [31:0] desc_dataout_addr,
    input  logic        desc_line_packed,
    input  logic        desc_surf_packed,
    input  logic [12:0] desc_dataout_height,
    input  logic [12:0] desc_dataout_width,
    input  logic [12:0] desc_dataout_channel,
    input  logic [23:0] desc_line_stride,
    input  logic [23:0] desc_surf_stride,
    input  logic        desc_conv_mode,
    input  logic [1:0]  desc_proc_precision,
    output logic [11:0] reg_offset,
    output logic        reg_wr_en,
    output logic [31:0] reg_wr_data,
    input  logic [31:0] reg_rd_data,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] done_sat_count,
    output logic        done_timeout,
    output logic        busy
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {StIdle, StWrite, StWait, StPoll, StSat, StDone} state_e;

    typedef struct packed {
        logic [4:0]  batches;
        logic [4:0]  clip_truncate;
        logic [31:0] cya;
        logic [31:0] dataout_addr;
        logic        line_packed;
        logic        surf_packed;
        logic [12:0] height;
        logic [12:0] width;
        logic [12:0] channel;
        logic [23:0] line_stride;
        logic [23:0] surf_stride;
        logic        conv_mode;
        logic [1:0]  proc_precision;
    } desc_t;

    function automatic logic [11:0] wr_offset(input logic [3:0] idx);
        case (idx)
            4'd0:    wr_offset = 12'h00c;
            4'd1:    wr_offset = 12'h010;
            4'd2:    wr_offset = 12'h014;
            4'd3:    wr_offset = 12'h018;
            4'd4:    wr_offset = 12'h01c;
            4'd5:    wr_offset = 12'h020;
            4'd6:    wr_offset = 12'h024;
            4'd7:    wr_offset = 12'h028;
            4'd8:    wr_offset = 12'h02c;
            4'd9:    wr_offset = 12'h034;
            4'd10:   wr_offset = 12'h008;
            default: wr_offset = 12'h000;
        endcase
    endfunction

    function automatic logic [31:0] wr_word(input logic [3:0] idx, input desc_t f);
        case (idx)
            4'd0:    wr_word = {18'b0, f.proc_precision, 11'b0, f.conv_mode};
            4'd1:    wr_word = {3'b0, f.height, 3'b0, f.width};
            4'd2:    wr_word = {19'b0, f.channel};
            4'd3:    wr_word = f.dataout_addr;
            4'd4:    wr_word = {27'b0, f.batches};
            4'd5:    wr_word = {8'b0, f.line_stride};
            4'd6:    wr_word = {8'b0, f.surf_stride};
            4'd7:    wr_word = {15'b0, f.surf_packed, 15'b0, f.line_packed};
            4'd8:    wr_word = {27'b0, f.clip_truncate};
            4'd9:    wr_word = f.cya;
            4'd10:   wr_word = 32'h1;
            default: wr_word = 32'h0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d, pcnt_inc;
    desc_t               fld_q, fld_d, fld_in;
    logic [31:0]         sat_q, sat_d;
    logic                to_q, to_d;
    logic [11:0]         offset_q, offset_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         wr_data_q, wr_data_d;

    assign fld_in = '{batches: desc_batches, clip_truncate: desc_clip_truncate, cya: desc_cya,
                      dataout_addr: desc_dataout_addr, line_packed: desc_line_packed,
                      surf_packed: desc_surf_packed, height: desc_dataout_height,
                      width: desc_dataout_width, channel: desc_dataout_channel,
                      line_stride: desc_line_stride, surf_stride: desc_surf_stride,
                      conv_mode: desc_conv_mode, proc_precision: desc_proc_precision};

    assign pcnt_inc = pcnt_q + PCNT_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pcnt_d    = pcnt_q;
        fld_d     = fld_q;
        sat_d     = sat_q;
        to_d      = to_q;
        offset_d  = 12'h000;
        wr_en_d   = 1'b0;
        wr_data_d = 32'h0;

        case (state_q)
            StIdle: begin
                if (desc_valid) begin
                    fld_d   = fld_in;
                    pcnt_d  = '0;
                    idx_d   = 4'd0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (idx_q == 4'd10) begin
                    gap_d   = '0;
                    state_d = StWait;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StWait: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = StPoll;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            StPoll: begin
                if (!reg_rd_data[0]) begin
                    state_d = StSat;
                end else begin
                    pcnt_d = pcnt_inc;
                    if (pcnt_inc == PCNT_W'(MAX_POLLS)) begin
                        state_d = StSat;
                    end else begin
                        gap_d   = '0;
                        state_d = StWait;
                    end
                end
            end
            StSat: begin
                sat_d   = reg_rd_data;
                // Counter only reaches the limit on the timeout path.
                to_d    = (pcnt_q == PCNT_W'(MAX_POLLS));
                state_d = StDone;
            end
            StDone: begin
                if (done_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Bus outputs are registered, so they are decoded from the upcoming state.
        case (state_d)
            StWrite: begin
                offset_d  = wr_offset(idx_d);
                wr_en_d   = 1'b1;
                wr_data_d = wr_word(idx_d, fld_d);
            end
            StPoll:  offset_d = 12'h008;
            StSat:   offset_d = 12'h030;
            default: offset_d = 12'h000;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            gap_q     <= '0;
            pcnt_q    <= '0;
            fld_q     <= '0;
            sat_q     <= '0;
            to_q      <= 1'b0;
            offset_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            pcnt_q    <= pcnt_d;
            fld_q     <= fld_d;
            sat_q     <= sat_d;
            to_q      <= to_d;
            offset_q  <= offset_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign reg_offset     = offset_q;
    assign reg_wr_en      = wr_en_q;
    assign reg_wr_data    = wr_data_q;
    assign done_valid     = (state_q == StDone);
    assign done_sat_count = sat_q;
    assign done_timeout   = to_q;
    assign busy           = (state_q != StIdle);
    assign desc_ready     = (state_q == StIdle);

endmodule

// File: tb/tb_cacc_dual_reg_prog.sv
// Directed bench for cacc_dual_reg_prog with a small op_en / OUT_SATURATION responder model.
module tb_cacc_dual_reg_prog;

    typedef struct packed {
        logic [4:0]  batches;
        logic [4:0]  clip;
        logic [31:0] cya;
        logic [31:0] addr;
        logic        lp;
        logic        sp;
        logic [12:0] h;
        logic [12:0] w;
        logic [12:0] ch;
        logic [23:0] ls;
        logic [23:0] ss;
        logic        conv;
        logic [1:0]  prec;
    } tdesc_t;

    localparam tdesc_t DESC_A = '{batches: 5'd3, clip: 5'd5, cya: 32'hDEADBEEF,
        addr: 32'h8000_0000, lp: 1'b1, sp: 1'b0, h: 13'd7, w: 13'd15, ch: 13'd63,
        ls: 24'h000100, ss: 24'h002000, conv: 1'b1, prec: 2'd2};
    localparam tdesc_t DESC_B = '{batches: 5'd31, clip: 5'd31, cya: 32'h0,
        addr: 32'h1234_5678, lp: 1'b0, sp: 1'b1, h: 13'h1FFF, w: 13'd0, ch: 13'h1FFF,
        ls: 24'hFFFFFF, ss: 24'h000001, conv: 1'b0, prec: 2'd1};

    logic [11:0] exp_off [11] = '{12'h00c, 12'h010, 12'h014, 12'h018, 12'h01c, 12'h020,
                                  12'h024, 12'h028, 12'h02c, 12'h034, 12'h008};
    logic [31:0] exp_a [11] = '{32'h0000_2001, 32'h0007_000F, 32'h0000_003F, 32'h8000_0000,
                                32'h3, 32'h100, 32'h2000, 32'h1, 32'h5, 32'hDEADBEEF, 32'h1};
    logic [31:0] exp_b [11] = '{32'h0000_1000, 32'h1FFF_0000, 32'h0000_1FFF, 32'h1234_5678,
                                32'h1F, 32'h00FF_FFFF, 32'h1, 32'h0001_0000, 32'h1F, 32'h0,
                                32'h1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        done_ready = 1'b0;
    tdesc_t      cur = '0;
    logic        op_en = 1'b0;
    logic [31:0] sat_val = 32'h0;
    logic [31:0] rd_data;

    logic        desc_ready, reg_wr_en, done_valid, done_timeout, busy;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data, done_sat_count;

    int checks = 0;
    int fails = 0;

    logic [11:0] wr_off [16];
    logic [31:0] wr_dat [16];
    int          wr_cyc [16];
    int          poll_cyc [64];
    int          nw, np, nsat, sat_cyc, done_cyc;

    always #5 clk = ~clk;

    always_comb begin
        rd_data = 32'h0;
        if (reg_offset == 12'h008)      rd_data = {31'b0, op_en};
        else if (reg_offset == 12'h030) rd_data = sat_val;
    end

    cacc_dual_reg_prog #(.POLL_GAP(4), .MAX_POLLS(8), .PCNT_W(4)) dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rst       (rst),
        .desc_valid           (desc_valid),
        .desc_ready           (desc_ready),
        .desc_batches         (cur.batches),
        .desc_clip_truncate   (cur.clip),
        .desc_cya             (cur.cya),
        .desc_dataout_addr    (cur.addr),
        .desc_line_packed     (cur.lp),
        .desc_surf_packed     (cur.sp),
        .desc_dataout_height  (cur.h),
        .desc_dataout_width   (cur.w),
        .desc_dataout_channel (cur.ch),
        .desc_line_stride     (cur.ls),
        .desc_surf_stride     (cur.ss),
        .desc_conv_mode       (cur.conv),
        .desc_proc_precision  (cur.prec),
        .reg_offset           (reg_offset),
        .reg_wr_en            (reg_wr_en),
        .reg_wr_data          (reg_wr_data),
        .reg_rd_data          (rd_data),
        .done_valid           (done_valid),
        .done_ready           (done_ready),
        .done_sat_count       (done_sat_count),
        .done_timeout         (done_timeout),
        .busy                 (busy)
    );

    // Called at a negedge while idle; returns at the negedge of cycle T+1.
    task automatic send(input tdesc_t d);
        cur = d;
        checks++;
        if (desc_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready got=%b exp=1", desc_ready);
        end
        desc_valid = 1'b1;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    // Records bus activity relative to the accept cycle until done_valid rises.
    task automatic watch(input int n_ones, input int limit);
        nw = 0; np = 0; nsat = 0; sat_cyc = -1; done_cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            if (reg_wr_en) begin
                if (nw < 16) begin
                    wr_off[nw] = reg_offset; wr_dat[nw] = reg_wr_data; wr_cyc[nw] = k;
                end
                nw++;
            end else if (reg_offset == 12'h008) begin
                op_en = (np < n_ones);
                if (np < 64) poll_cyc[np] = k;
                np++;
            end else if (reg_offset == 12'h030) begin
                sat_cyc = k;
                nsat++;
            end
            if (done_valid) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL watch_done got=none exp=done_valid within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (reg_offset !== 12'h0)     begin fails++; $display("FAIL rst_offset got=%h exp=0", reg_offset); end
        if (reg_wr_en !== 1'b0)       begin fails++; $display("FAIL rst_wr_en got=%b exp=0", reg_wr_en); end
        if (reg_wr_data !== 32'h0)    begin fails++; $display("FAIL rst_wr_data got=%h exp=0", reg_wr_data); end
        if (done_valid !== 1'b0)      begin fails++; $display("FAIL rst_done_valid got=%b exp=0", done_valid); end
        if (done_sat_count !== 32'h0) begin fails++; $display("FAIL rst_sat got=%h exp=0", done_sat_count); end
        if (done_timeout !== 1'b0)    begin fails++; $display("FAIL rst_timeout got=%b exp=0", done_timeout); end
        if (busy !== 1'b0)            begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (desc_ready !== 1'b1)      begin fails++; $display("FAIL rst_ready got=%b exp=1", desc_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sat_val = 32'h1234;
        send(DESC_A);
        cur = '1;  // inputs change after accept; captured copy must not
        watch(3, 200);
        checks++;
        if (nw !== 11) begin fails++; $display("FAIL basic_nwrites got=%0d exp=11", nw); end
        for (int i = 0; i < 11; i++) begin
            checks += 3;
            if (wr_off[i] !== exp_off[i]) begin fails++; $display("FAIL basic_off[%0d] got=%h exp=%h", i, wr_off[i], exp_off[i]); end
            if (wr_dat[i] !== exp_a[i])   begin fails++; $display("FAIL basic_dat[%0d] got=%h exp=%h", i, wr_dat[i], exp_a[i]); end
            if (wr_cyc[i] !== i + 1)      begin fails++; $display("FAIL basic_cyc[%0d] got=%0d exp=%0d", i, wr_cyc[i], i + 1); end
        end
        checks++;
        if (np !== 4) begin fails++; $display("FAIL basic_npolls got=%0d exp=4", np); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (poll_cyc[i] !== 16 + 5 * i) begin
                fails++; $display("FAIL basic_poll[%0d] got=%0d exp=%0d", i, poll_cyc[i], 16 + 5 * i);
            end
        end
        checks += 6;
        if (nsat !== 1)                  begin fails++; $display("FAIL basic_nsat got=%0d exp=1", nsat); end
        if (sat_cyc !== 32)              begin fails++; $display("FAIL basic_sat_cyc got=%0d exp=32", sat_cyc); end
        if (done_cyc !== 33)             begin fails++; $display("FAIL basic_done_cyc got=%0d exp=33", done_cyc); end
        if (done_sat_count !== 32'h1234) begin fails++; $display("FAIL basic_sat got=%h exp=1234", done_sat_count); end
        if (done_timeout !== 1'b0)       begin fails++; $display("FAIL basic_timeout got=%b exp=0", done_timeout); end
        if (busy !== 1'b1)               begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checks += 3;
        if (done_valid !== 1'b0) begin fails++; $display("FAIL basic_release_valid got=%b exp=0", done_valid); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL basic_release_busy got=%b exp=0", busy); end
        if (desc_ready !== 1'b1) begin fails++; $display("FAIL basic_release_ready got=%b exp=1", desc_ready); end
    endtask

    task automatic test_timeout();
        sat_val = 32'hCAFE;
        send(DESC_B);
        cur = '0;
        watch(1000, 200);
        checks++;
        if (nw !== 11) begin fails++; $display("FAIL to_nwrites got=%0d exp=11", nw); end
        for (int i = 0; i < 11; i++) begin
            checks += 2;
            if (wr_off[i] !== exp_off[i]) begin fails++; $display("FAIL to_off[%0d] got=%h exp=%h", i, wr_off[i], exp_off[i]); end
            if (wr_dat[i] !== exp_b[i])   begin fails++; $display("FAIL to_dat[%0d] got=%h exp=%h", i, wr_dat[i], exp_b[i]); end
        end
        checks += 6;
        if (np !== 8)                    begin fails++; $display("FAIL to_npolls got=%0d exp=8", np); end
        if (poll_cyc[7] !== 51)          begin fails++; $display("FAIL to_last_poll got=%0d exp=51", poll_cyc[7]); end
        if (sat_cyc !== 52)              begin fails++; $display("FAIL to_sat_cyc got=%0d exp=52", sat_cyc); end
        if (done_cyc !== 53)             begin fails++; $display("FAIL to_done_cyc got=%0d exp=53", done_cyc); end
        if (done_timeout !== 1'b1)       begin fails++; $display("FAIL to_timeout got=%b exp=1", done_timeout); end
        if (done_sat_count !== 32'hCAFE) begin fails++; $display("FAIL to_sat got=%h exp=cafe", done_sat_count); end
    endtask

    // Entered with the DUT sitting in DONE from test_timeout.
    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            desc_valid = i[0];
            cur = (i[0]) ? DESC_A : DESC_B;
            @(negedge clk);
            checks += 6;
            if (done_valid !== 1'b1)         begin fails++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, done_valid); end
            if (done_sat_count !== 32'hCAFE) begin fails++; $display("FAIL hold_sat[%0d] got=%h exp=cafe", i, done_sat_count); end
            if (done_timeout !== 1'b1)       begin fails++; $display("FAIL hold_to[%0d] got=%b exp=1", i, done_timeout); end
            if (desc_ready !== 1'b0)         begin fails++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, desc_ready); end
            if (reg_wr_en !== 1'b0)          begin fails++; $display("FAIL hold_wr_en[%0d] got=%b exp=0", i, reg_wr_en); end
            if (reg_offset !== 12'h0)        begin fails++; $display("FAIL hold_off[%0d] got=%h exp=0", i, reg_offset); end
        end
        desc_valid = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checks += 4;
        if (done_valid !== 1'b0)         begin fails++; $display("FAIL hold_exit_valid got=%b exp=0", done_valid); end
        if (busy !== 1'b0)               begin fails++; $display("FAIL hold_exit_busy got=%b exp=0", busy); end
        if (done_sat_count !== 32'hCAFE) begin fails++; $display("FAIL hold_exit_sat got=%h exp=cafe", done_sat_count); end
        if (done_timeout !== 1'b1)       begin fails++; $display("FAIL hold_exit_to got=%b exp=1", done_timeout); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        sat_val = 32'h0;
        send(DESC_A);
        for (int k = 0; k < 20; k++) begin
            if (reg_wr_en && reg_offset == 12'h020) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin fails++; $display("FAIL rmid_find_idx5 got=none exp=write 0x020"); end
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (reg_wr_en !== 1'b0)       begin fails++; $display("FAIL rmid_wr_en got=%b exp=0", reg_wr_en); end
        if (busy !== 1'b0)            begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        if (desc_ready !== 1'b1)      begin fails++; $display("FAIL rmid_ready got=%b exp=1", desc_ready); end
        if (done_timeout !== 1'b0)    begin fails++; $display("FAIL rmid_timeout got=%b exp=0", done_timeout); end
        if (done_sat_count !== 32'h0) begin fails++; $display("FAIL rmid_sat got=%h exp=0", done_sat_count); end
        rst = 1'b0;
        @(negedge clk);
        sat_val = 32'h55;
        send(DESC_B);
        watch(0, 100);
        checks += 7;
        if (nw !== 11)                 begin fails++; $display("FAIL rmid_nwrites got=%0d exp=11", nw); end
        if (wr_off[0] !== 12'h00c)     begin fails++; $display("FAIL rmid_first_off got=%h exp=00c", wr_off[0]); end
        if (wr_dat[0] !== 32'h1000)    begin fails++; $display("FAIL rmid_first_dat got=%h exp=1000", wr_dat[0]); end
        if (wr_cyc[0] !== 1)           begin fails++; $display("FAIL rmid_first_cyc got=%0d exp=1", wr_cyc[0]); end
        if (done_cyc !== 18)           begin fails++; $display("FAIL rmid_done_cyc got=%0d exp=18", done_cyc); end
        if (done_sat_count !== 32'h55) begin fails++; $display("FAIL rmid_sat got=%h exp=55", done_sat_count); end
        if (done_timeout !== 1'b0)     begin fails++; $display("FAIL rmid_timeout got=%b exp=0", done_timeout); end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        done_ready = 1'b1;
        sat_val = 32'h11;
        send(DESC_A);
        watch(0, 100);
        checks += 2;
        if (done_cyc !== 18)           begin fails++; $display("FAIL b2b_first_done got=%0d exp=18", done_cyc); end
        if (done_sat_count !== 32'h11) begin fails++; $display("FAIL b2b_first_sat got=%h exp=11", done_sat_count); end
        // Offer the next descriptor while DONE is exiting; it must wait one cycle.
        cur = DESC_B;
        desc_valid = 1'b1;
        sat_val = 32'h22;
        @(negedge clk);
        checks += 2;
        if (desc_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", desc_ready); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL b2b_idle got=%b exp=0", busy); end
        @(negedge clk);
        desc_valid = 1'b0;
        watch(0, 100);
        checks++;
        if (nw !== 11) begin fails++; $display("FAIL b2b_nwrites got=%0d exp=11", nw); end
        for (int i = 0; i < 11; i++) begin
            checks += 2;
            if (wr_off[i] !== exp_off[i]) begin fails++; $display("FAIL b2b_off[%0d] got=%h exp=%h", i, wr_off[i], exp_off[i]); end
            if (wr_dat[i] !== exp_b[i])   begin fails++; $display("FAIL b2b_dat[%0d] got=%h exp=%h", i, wr_dat[i], exp_b[i]); end
        end
        checks += 2;
        if (done_cyc !== 18)           begin fails++; $display("FAIL b2b_second_done got=%0d exp=18", done_cyc); end
        if (done_sat_count !== 32'h22) begin fails++; $display("FAIL b2b_second_sat got=%h exp=22", done_sat_count); end
        @(negedge clk);
        done_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
